// File: rtl/mux_sched_pkg.sv
// Shared types and default sizes for the 8:1 round-robin selector scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_sched_pkg;

   localparam int N_REQ_DEF    = 8;
   localparam int DW_DEF       = 4;
   localparam int MAX_HOLD_DEF = 16;
   localparam int AW_DEF       = $clog2(N_REQ_DEF);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   typedef logic [AW_DEF-1:0] addr_t;
   typedef logic [DW_DEF-1:0] data_t;

endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// Requester-side bundle of the shared selector: requests and data in, grant and selected word out.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req high for as long as they need the selector.
interface mux8_rr_scheduler_if
   import mux_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int DW    = DW_DEF
);
   localparam int AW = $clog2(N_REQ);

   logic [N_REQ-1:0]    req;
   logic [N_REQ*DW-1:0] din;
   logic [N_REQ-1:0]    gnt;
   logic [AW-1:0]       addr;
   logic                valid;
   logic [DW-1:0]       dout;
   logic                preempt;

   modport master (output req, din, input gnt, addr, valid, dout, preempt);
   modport slave  (input req, din, output gnt, addr, valid, dout, preempt);

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible (req & mask) index searching ptr, ptr+1, ... modulo N_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on the winner.
module rr_pick #(
   parameter int N_REQ = 8
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   input  logic [N_REQ-1:0]         mask,
   output logic                     any,
   output logic [$clog2(N_REQ)-1:0] winner
);
   localparam int AW = $clog2(N_REQ);

   logic [N_REQ-1:0] eligible;
   logic [AW-1:0]    idx;

   assign eligible = req & mask;

   // Walk from the farthest offset back to ptr so the nearest eligible index is written last.
   always_comb begin
      any    = 1'b0;
      winner = ptr;
      idx    = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = ptr + AW'(k);
         if (eligible[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of one shared N:1 selector; registered one-hot grant, address and selected word.
// Latency: req -> gnt/addr 1 cycle; addr -> dout 1 further cycle.
// Backpressure: owner keeps the grant while req stays high; MUX_SCHED_TIMEOUT_EN adds forced rotation after MAX_HOLD cycles.
module mux8_rr_scheduler
   import mux_sched_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input logic                clk,
   input logic                rst_n,
   mux8_rr_scheduler_if.slave bus
);
   localparam int AW = $clog2(N_REQ);

   state_e           state_q, state_d;
   logic [AW-1:0]    owner_q, owner_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_q;
   logic [DW-1:0]    dout_q;
   logic             new_grant;
   logic             pre_d;

   logic [AW-1:0]    pick_ptr;
   logic [N_REQ-1:0] pick_mask;
   logic             pick_any;
   logic [AW-1:0]    pick_win;

   logic [DW-1:0]    din_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_din
      assign din_arr[i] = bus.din[i*DW +: DW];
   end

`ifdef MUX_SCHED_TIMEOUT_EN
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
   logic [HW-1:0] hold_q;
   logic          pre_q;
`endif

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (bus.req),
      .ptr    (pick_ptr),
      .mask   (pick_mask),
      .any    (pick_any),
      .winner (pick_win)
   );

   // Next owner / pointer: fresh arbitration when idle, release handoff or forced rotation when busy.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      new_grant = 1'b0;
      pre_d     = 1'b0;
      pick_ptr  = ptr_q;
      pick_mask = '1;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d   = BUSY;
               owner_d   = pick_win;
               new_grant = 1'b1;
            end
         end
         BUSY: begin
            // Both release and rotation search from the slot after the owner, never the owner itself.
            pick_ptr  = owner_q + 1'b1;
            pick_mask = ~({{(N_REQ-1){1'b0}}, 1'b1} << owner_q);
            if (!bus.req[owner_q]) begin
               ptr_d = owner_q + 1'b1;
               if (pick_any) begin
                  owner_d   = pick_win;
                  new_grant = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
`ifdef MUX_SCHED_TIMEOUT_EN
            else if (hold_q == HOLD_LIM && pick_any) begin
               ptr_d     = owner_q + 1'b1;
               owner_d   = pick_win;
               new_grant = 1'b1;
               pre_d     = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State, owner (doubles as addr, holds in IDLE) and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   // One-hot grant registered alongside the owner so both change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q <= '0;
      end else if (state_d == BUSY) begin
         gnt_q <= {{(N_REQ-1){1'b0}}, 1'b1} << owner_d;
      end else begin
         gnt_q <= '0;
      end
   end

   // Selected word follows the current owner one cycle behind addr; holds while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else if (state_q == BUSY) begin
         dout_q <= din_arr[owner_q];
      end
   end

`ifdef MUX_SCHED_TIMEOUT_EN
   // Cycles held by the current owner; restarts on every new grant and saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (state_d != BUSY || new_grant) begin
         hold_q <= '0;
      end else if (hold_q != HOLD_LIM) begin
         hold_q <= hold_q + 1'b1;
      end
   end

   // Preempt flag is high for the first cycle of a grant obtained by forced rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= 1'b0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign bus.preempt = pre_q;
`else
   assign bus.preempt = 1'b0;
`endif

   assign bus.gnt   = gnt_q;
   assign bus.addr  = owner_q;
   assign bus.valid = (state_q == BUSY);
   assign bus.dout  = dout_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: directed scenarios plus randomized traffic vs a queue-free RR model.
// Latency: checks 1-cycle req->gnt and 1-cycle addr->dout.
// Backpressure: exercises release handoff and, with MUX_SCHED_TIMEOUT_EN, forced rotation (MAX_HOLD=4).
module tb_mux8_rr_scheduler;
   import mux_sched_pkg::*;

   localparam int N    = 8;
   localparam int W    = 4;
   localparam int MAXH = 4;
   localparam int VW   = N + 3 + 1 + W + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   mux8_rr_scheduler_if #(.N_REQ(N), .DW(W)) bus ();

   mux8_rr_scheduler #(.N_REQ(N), .DW(W), .MAX_HOLD(MAXH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   logic [VW-1:0] obs_vec;
   assign obs_vec = {bus.gnt, bus.addr, bus.valid, bus.dout, bus.preempt};

   // Reference model state: owner index (-1 = nobody), search start, cycles held.
   int    m_owner;
   int    m_ptr;
   int    m_hold;
   addr_t m_addr;
   data_t m_dout;
   logic  m_pre;

   function automatic int rr_search(logic [N-1:0] r, int from, int excl);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (from + k) % N;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_addr  = '0;
      m_dout  = '0;
      m_pre   = 1'b0;
   endtask

   // Applies the scheduling rules to the inputs present at the coming edge.
   task automatic model_edge();
      logic [N-1:0]   r;
      logic [N*W-1:0] d;
      int             nxt;
      r     = bus.req;
      d     = bus.din;
      m_pre = 1'b0;
      if (m_owner >= 0) m_dout = d[m_owner*W +: W];
      if (m_owner < 0) begin
         nxt = rr_search(r, m_ptr, -1);
         if (nxt >= 0) begin
            m_owner = nxt;
            m_hold  = 0;
         end
      end else if (!r[m_owner]) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = rr_search(r, m_ptr, -1);
         m_hold  = 0;
      end else begin
`ifdef MUX_SCHED_TIMEOUT_EN
         nxt = rr_search(r, (m_owner + 1) % N, m_owner);
         if (m_hold == MAXH - 1 && nxt >= 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = nxt;
            m_hold  = 0;
            m_pre   = 1'b1;
         end else if (m_hold < MAXH - 1) begin
            m_hold = m_hold + 1;
         end
`endif
      end
      if (m_owner >= 0) m_addr = addr_t'(m_owner);
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return {g, m_addr, (m_owner >= 0), m_dout, m_pre};
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      bus.req = 8'hFF;
      bus.din = $urandom;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (obs_vec !== '0) begin
         bad++;
         $display("FAIL reset: got gnt=%h addr=%0d valid=%b dout=%h pre=%b, want all zero",
                  bus.gnt, bus.addr, bus.valid, bus.dout, bus.preempt);
      end
      bus.req = '0;
      rst_n   = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      logic [N*W-1:0] d;
      d = {$urandom, $urandom};
      d[2*W +: W] = 4'hA;
      bus.din = d;
      bus.req = 8'h04;
      tick();
      total++;
      if (bus.gnt !== 8'h04 || bus.addr !== 3'd2 || bus.valid !== 1'b1) begin
         bad++;
         $display("FAIL single_grant: got gnt=%h addr=%0d valid=%b, want 04/2/1", bus.gnt, bus.addr, bus.valid);
      end
      tick();
      total++;
      if (bus.dout !== 4'hA || obs_vec !== exp_vec()) begin
         bad++;
         $display("FAIL single_dout: got dout=%h vec=%h, want dout=a vec=%h", bus.dout, obs_vec, exp_vec());
      end
      bus.req = '0;
      tick();
      total++;
      if (bus.gnt !== 8'h00 || bus.valid !== 1'b0 || bus.addr !== 3'd2) begin
         bad++;
         $display("FAIL single_release: got gnt=%h valid=%b addr=%0d, want 00/0/2", bus.gnt, bus.valid, bus.addr);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      bus.din = {$urandom, $urandom};
      bus.req = 8'hFF;
      tick();
      total++;
      if (bus.gnt !== 8'h01) begin
         bad++;
         $display("FAIL rr_first: got gnt=%h, want 01", bus.gnt);
      end
      for (int k = 1; k <= 9; k++) begin
         logic [N-1:0] want;
         bus.req = 8'hFF & ~(8'h01 << m_owner);
         bus.din = {$urandom, $urandom};
         tick();
         want = 8'h01 << (k % N);
         total++;
         if (bus.gnt !== want || bus.valid !== 1'b1 || obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL rr_step%0d: got gnt=%h valid=%b vec=%h, want gnt=%h vec=%h",
                     k, bus.gnt, bus.valid, obs_vec, want, exp_vec());
         end
      end
   endtask

   task automatic test_fairness();
      apply_reset();
      bus.req = 8'h20;
      tick();
      bus.req = 8'h21;
      tick();
      total++;
      if (bus.gnt !== 8'h20) begin
         bad++;
         $display("FAIL fair_hold: got gnt=%h, want 20", bus.gnt);
      end
      bus.req = 8'h01;
      tick();
      total++;
      if (bus.gnt !== 8'h01 || bus.addr !== 3'd0 || obs_vec !== exp_vec()) begin
         bad++;
         $display("FAIL fair_handoff: got gnt=%h addr=%0d, want 01/0", bus.gnt, bus.addr);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      bus.req = 8'h03;
      for (int t = 1; t <= 12; t++) begin
         logic [N-1:0] want_g;
         logic         want_p;
         bus.din = {$urandom, $urandom};
         tick();
`ifdef MUX_SCHED_TIMEOUT_EN
         want_g = (((t - 1) / MAXH) % 2 == 1) ? 8'h02 : 8'h01;
         want_p = (t > 1) && ((t - 1) % MAXH == 0);
`else
         want_g = 8'h01;
         want_p = 1'b0;
`endif
         total++;
         if (bus.gnt !== want_g || bus.preempt !== want_p || obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL timeout_c%0d: got gnt=%h preempt=%b, want gnt=%h preempt=%b",
                     t, bus.gnt, bus.preempt, want_g, want_p);
         end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      bus.req = 8'h08;
      tick();
      tick();
      total++;
      if (bus.gnt !== 8'h08 || bus.addr !== 3'd3) begin
         bad++;
         $display("FAIL midrst_own: got gnt=%h addr=%0d, want 08/3", bus.gnt, bus.addr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs_vec !== '0) begin
         bad++;
         $display("FAIL midrst_clear: got vec=%h, want 0", obs_vec);
      end
      model_reset();
      @(posedge clk); #1;
      bus.req = 8'hFF;
      rst_n   = 1'b1;
      tick();
      total++;
      if (bus.gnt !== 8'h01 || bus.addr !== 3'd0) begin
         bad++;
         $display("FAIL midrst_ptr: got gnt=%h addr=%0d, want 01/0", bus.gnt, bus.addr);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] r;
         r = N'($urandom);
         if ($urandom_range(0, 2) == 0) r = r & N'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
         bus.req = r;
         bus.din = {$urandom, $urandom};
         tick();
         total++;
         if (obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL random_c%0d: req=%h got vec=%h want vec=%h", c, r, obs_vec, exp_vec());
         end
      end
   endtask

   initial begin
      bus.req = '0;
      bus.din = '0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_timeout();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
